vpu_dst_port: RTL
=================

// Module: vpu_dst_port
// PURPOSE
// Destination write stage directly downstream of the VPU FP arithmetic units (e.g. FP average).
// Captures each result/done pulse from the FP pipeline into a small FIFO.
// Writes the results to consecutive addresses through one SRAM write port.
// Signals completion of a vector command to VPU_CONTROLLER.
// FP pipelines cannot stall, so this block absorbs SRAM write-port backpressure.
// PARAMETERS
// DATA_W      16  result width; equals VPU_PKG::OPERAND_WIDTH (bf16)
// ADDR_W      8   SRAM word-address width; also width of the element count
// FIFO_DEPTH  4   result buffer entries; power of two, >= 2
// PORTS
// clk             in   1       single clock; all logic rising-edge
// rst             in   1       synchronous, active-high reset
// start_i         in   1       1-cycle command strobe from VPU_CONTROLLER
// dst_addr_i      in   ADDR_W  base write address; sampled when start_i accepted
// elem_cnt_i      in   ADDR_W  number of results expected; sampled with start_i
// result_i        in   DATA_W  FP unit result data (FP unit result_o)
// result_valid_i  in   1       FP unit done_o; result_i valid this cycle
// sram_wready_i   in   1       SRAM write port accepts a write this cycle
// sram_we_o       out  1       write request
// sram_waddr_o    out  ADDR_W  write address
// sram_wdata_o    out  DATA_W  write data (FIFO head)
// busy_o          out  1       command in progress (state RUN)
// done_o          out  1       1-cycle pulse: command complete
// overflow_o      out  1       sticky: a result was dropped
// BEHAVIOUR
// Reset:
// - all outputs 0; state IDLE; FIFO empty; address and remaining count 0.
// - Reset mid-command aborts it: no done_o, buffered data discarded.
// FSM states: IDLE, RUN, FIN.
// - IDLE + start_i, elem_cnt_i!=0: latch addr/count; clear overflow_o; go to RUN.
// - IDLE + start_i, elem_cnt_i==0: clear overflow_o; go to FIN (no writes).
// - RUN: when the write that takes remaining from 1 to 0 is accepted (sram_we_o & sram_wready_i), go to FIN.
// - FIN: done_o=1 for exactly this cycle; go to IDLE.
// - start_i in RUN or FIN is ignored.
// Write port:
// - sram_we_o = (state==RUN) & FIFO not empty.
// - sram_wdata_o = FIFO head.
// - sram_waddr_o = current address register.
// - Outputs hold stable while sram_we_o=1 and sram_wready_i=0.
// - On acceptance: pop FIFO; address +1 modulo 2^ADDR_W (0xFF -> 0x00 wraps); remaining -1.
// Push rules:
// - In RUN, result_valid_i pushes result_i, accepted if FIFO not full OR a pop occurs the same cycle.
// - Simultaneous push+pop at full is legal; occupancy is unchanged.
// - Push refused (full, no pop): result dropped; overflow_o set next cycle, held until next accepted start_i.
// - result_valid_i in IDLE or FIN: dropped and sets overflow_o.
// - Results beyond elem_cnt in RUN are impossible by contract; they may sit in the FIFO but are never written after FIN.
// - FIFO is flushed on entry to IDLE.
// Latency: result_valid_i at cycle t into an empty FIFO with sram_wready_i=1 -> sram_we_o=1 at t+1.
// Throughput: one write per cycle sustained.
// TESTING
// T1 basic: start addr=0x10, cnt=3; results 0x3F80,0x4000,0x4040 on consecutive cycles; wready=1
//    -> writes (0x10,0x3F80),(0x11,0x4000),(0x12,0x4040), each 1 cycle after its valid; done_o pulses the cycle after the last write.
// T2 wrap: addr=0xFE, cnt=3 -> waddr 0xFE,0xFF,0x00; done_o once; busy_o low after FIN.
// T3 overflow: cnt=5; wready=0 for 8 cycles; 5 results back-to-back
//    -> 4 buffered, 5th dropped; overflow_o=1 from the cycle after the 5th valid;
//    wready=1 -> 4 writes, no done_o; held until new start clears.
// T4 full push+pop: FIFO full, result_valid_i=1 and wready=1 same cycle
//    -> push accepted, occupancy stays 4, overflow_o stays 0, data order preserved.
// T5 zero count: start with cnt=0 -> done_o=1 next cycle, no sram_we_o; start_i during FIN ignored.
// T6 reset mid-op: rst=1 during RUN with 2 entries buffered
//    -> next cycle all outputs 0, no done_o; new command afterwards behaves like T1.

Source files
------------

// File: rtl/vpu_dst_port.sv
// rtl/vpu_dst_port.sv - buffers FP unit results in a small FIFO and writes them to consecutive SRAM addresses
module vpu_dst_port #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [ADDR_W-1:0] elem_cnt_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              result_valid_i,
  input  logic              sram_wready_i,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_waddr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [PTR_W:0]  PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic              overflow;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign sram_we_o    = (state == S_RUN) && !fifo_empty;
  assign sram_waddr_o = addr;
  assign sram_wdata_o = mem[rd_ptr[PTR_W-1:0]];
  assign busy_o       = (state == S_RUN);
  assign done_o       = (state == S_FIN);
  assign overflow_o   = overflow;

  // A pop frees a slot in the same cycle, so a push at full still fits.
  assign pop  = sram_we_o && sram_wready_i;
  assign push = (state == S_RUN) && result_valid_i && (!fifo_full || pop);
  assign drop = result_valid_i && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      addr      <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= result_i;
        wr_ptr                 <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        addr      <= addr + ADDR_ONE;
        remaining <= remaining - ADDR_ONE;
      end

      case (state)
        S_IDLE: begin
          if (start_i) begin
            overflow <= 1'b0;
            if (elem_cnt_i != '0) begin
              addr      <= dst_addr_i;
              remaining <= elem_cnt_i;
              state     <= S_RUN;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          if (pop && remaining == ADDR_ONE) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          // Leftover results past the element count are discarded here.
          state  <= S_IDLE;
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        default: state <= S_IDLE;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
